// File: rtl/div_pkg.sv
// Shared types for the divider issue controller: FSM states, result status codes, default width.
package div_pkg;

    localparam int DIV_WIDTH = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD
    } state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_DVZ     = 2'b01;
    localparam status_t ST_OVF     = 2'b10;
    localparam status_t ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/div_watchdog.sv
// Cycle watchdog for the divider wait states; only instantiated when DIV_TIMEOUT_EN is defined.
module div_watchdog #(
    parameter int unsigned LIMIT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // expired fires in the cycle whose count, including itself, reaches LIMIT
    always_comb begin
        expired = enable && ((32'(cnt_q) + 32'd1) >= LIMIT);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Operand/result handshake wrapper around an external divider. Optional watchdog: DIV_TIMEOUT_EN.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int          WIDTH   = DIV_WIDTH,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic             div_ovf,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [1:0]       out_status
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("div_issue_ctrl: TIMEOUT must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
    status_t          status_q, status_d;
    logic             wd_expired;

`ifdef DIV_TIMEOUT_EN
    logic wd_active;
    assign wd_active = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);

    div_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!wd_active),
        .enable (wd_active),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        q_d      = q_q;
        r_d      = r_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (in_b == '0) begin
                        state_d  = S_HOLD;
                        status_d = ST_DVZ;
                        q_d      = '0;
                        r_d      = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (wd_expired) begin
                    state_d  = S_HOLD;
                    status_d = ST_TIMEOUT;
                    q_d      = '0;
                    r_d      = '0;
                end else if (div_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // overflow outranks a same-cycle valid; a valid outranks the watchdog
                if (div_ovf || (!div_busy && !div_valid)) begin
                    state_d  = S_HOLD;
                    status_d = ST_OVF;
                    q_d      = '0;
                    r_d      = '0;
                end else if (div_valid) begin
                    state_d  = S_HOLD;
                    status_d = ST_OK;
                    q_d      = div_q;
                    r_d      = div_r;
                end else if (wd_expired) begin
                    state_d  = S_HOLD;
                    status_d = ST_TIMEOUT;
                    q_d      = '0;
                    r_d      = '0;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            status_q <= status_d;
        end
    end

    // outputs are forced low for the whole time rst is high, including its first cycle
    assign in_ready   = !rst && (state_q == S_IDLE);
    assign div_start  = !rst && (state_q == S_ISSUE);
    assign out_valid  = !rst && (state_q == S_HOLD);
    assign div_a      = rst ? '0 : a_q;
    assign div_b      = rst ? '0 : b_q;
    assign out_q      = rst ? '0 : q_q;
    assign out_r      = rst ? '0 : r_q;
    assign out_status = rst ? ST_OK : status_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl with a behavioural divider and result reference model.
module tb_div_issue_ctrl;

    localparam int W = 10;
`ifdef DIV_TIMEOUT_EN
    localparam int TMO = 20;
    localparam int NMODES = 5;
`else
    localparam int TMO = 200;
    localparam int NMODES = 4;
`endif

    typedef enum int {M_OK, M_OVF_DROP, M_ABORT, M_OVF_VALID, M_NOBUSY} mode_e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic         div_start;
    logic [W-1:0] div_a, div_b;
    logic         div_busy, div_valid, div_ovf;
    logic [W-1:0] div_q, div_r;
    logic         out_valid, out_ready;
    logic [W-1:0] out_q, out_r;
    logic [1:0]   out_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .WIDTH  (W),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_ovf   (div_ovf),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_status(out_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected outcome of one transaction: status, quotient, remainder and the number of
    // cycles after the start cycle until out_valid is seen.
    function automatic void ref_result(input mode_e m, input int a, input int b, input int lat,
                                       output int st, output int q, output int r, output int cyc);
        st = 0; q = 0; r = 0; cyc = 0;
        if (b == 0) begin
            st = 1;
        end else begin
            case (m)
                M_OK:     begin st = 0; q = a / b; r = a % b; cyc = lat + 1; end
                M_NOBUSY: begin st = 3; cyc = TMO + 1; end
                default:  begin st = 2; cyc = lat + 1; end
            endcase
        end
    endfunction

    task automatic clear_div();
        div_busy = 1'b0; div_valid = 1'b0; div_ovf = 1'b0; div_q = '0; div_r = '0;
    endtask

    // Divider behaviour in cycle c after the start pulse
    task automatic drive_div(input mode_e m, input int c, input int lat, input int a, input int b);
        clear_div();
        case (m)
            M_OK: begin
                div_busy = (c <= lat);
                if (c == lat) begin
                    div_valid = 1'b1; div_q = W'(a / b); div_r = W'(a % b);
                end
            end
            M_OVF_VALID: begin
                div_busy = (c <= lat);
                if (c == lat) begin
                    div_valid = 1'b1; div_ovf = 1'b1;
                    div_q = W'($urandom_range(1, 1023)); div_r = W'($urandom_range(1, 1023));
                end
            end
            M_OVF_DROP: begin
                div_busy = (c < lat);
                div_ovf  = (c == lat);
            end
            M_ABORT:  div_busy = (c < lat);
            default:  ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        clear_div();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_txn(input int a, input int b, input mode_e m, input int lat, input int hold);
        int est, eq, er, ecyc, c, starts;
        ref_result(m, a, b, lat, est, eq, er, ecyc);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1; in_a = W'(a); in_b = W'(b);
        @(negedge clk);
        in_valid = 1'b0;
        check("div_a_latched", div_a, a);
        check("div_b_latched", div_b, b);
        c = 0;
        starts = 0;
        if (b == 0) begin
            check("dvz_no_start", div_start, 0);
        end else begin
            check("start_pulse", div_start, 1);
            while (c < TMO + 30) begin
                @(negedge clk);
                c++;
                if (out_valid) break;
                if (div_start) starts++;
                out_ready = 1'($urandom_range(0, 1));
                drive_div(m, c, lat, a, b);
            end
            clear_div();
            out_ready = 1'b0;
            check("single_start", starts, 0);
        end
        if (!out_valid) begin
            check("out_valid_wait", out_valid, 1);
            do_reset();
            return;
        end
        check("latency", c, ecyc);
        check("status", out_status, est);
        check("out_q", out_q, eq);
        check("out_r", out_r, er);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_q", out_q, eq);
            check("hold_r", out_r, er);
            check("hold_status", out_status, est);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_a = W'(a + 1); in_b = W'(b + 1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("no_accept_a", div_a, a);
        check("no_accept_b", div_b, b);
    endtask

    task automatic reset_mid();
        in_valid = 1'b1; in_a = W'(500); in_b = W'(9);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive_div(M_OK, c, 8, 500, 9);
        end
        rst = 1'b1;
        #1;
        check("rst_now_valid", out_valid, 0);
        check("rst_now_in_ready", in_ready, 0);
        check("rst_now_div_a", div_a, 0);
        @(negedge clk);
        drive_div(M_OK, 4, 8, 500, 9);
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_start", div_start, 0);
        check("rst_q", out_q, 0);
        check("rst_r", out_r, 0);
        check("rst_status", out_status, 0);
        check("rst_div_a", div_a, 0);
        check("rst_div_b", div_b, 0);
        rst = 1'b0;
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) check("post_rst_in_ready", in_ready, 1);
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_no_start", div_start, 0);
            drive_div(M_OK, c, 8, 500, 9);
        end
        clear_div();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        clear_div();
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_div_start", div_start, 0);
        check("reset_status", out_status, 0);
        check("reset_div_a", div_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("first_in_ready", in_ready, 1);

        run_txn(100, 7, M_OK, 6, 5);
        run_txn(55, 0, M_OK, 0, 2);
        run_txn(300, 11, M_OVF_DROP, 4, 1);
        run_txn(300, 11, M_ABORT, 3, 0);
        run_txn(123, 5, M_OVF_VALID, 5, 1);
        run_txn(200, 3, M_OK, TMO, 1);
`ifdef DIV_TIMEOUT_EN
        run_txn(200, 3, M_NOBUSY, 0, 1);
`endif
        reset_mid();

        for (int t = 0; t < 40; t++) begin
            int a, b, lat, hold;
            mode_e m;
            m    = mode_e'($urandom_range(0, NMODES - 1));
            a    = int'($urandom_range(0, 1023));
            b    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1023));
            lat  = int'($urandom_range(2, 10));
            hold = int'($urandom_range(0, 4));
            run_txn(a, b, m, lat, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
